// File: rtl/nic_defs.sv
// Shared NIC definitions: CCI-P c0 channel types, the RPC record, and the
// RX ring conventions agreed with the host driver.
package nic_defs;

    localparam int CCIP_CLADDR_W = 42;
    localparam int CCIP_MDATA_W  = 16;
    localparam int CCIP_CLDATA_W = 512;

    typedef logic [CCIP_CLADDR_W-1:0] t_ccip_clAddr;
    typedef logic [CCIP_MDATA_W-1:0]  t_ccip_mdata;
    typedef logic [CCIP_CLDATA_W-1:0] t_ccip_clData;

    typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc      vc_sel;
        logic [1:0]    rsvd1;
        t_ccip_clLen   cl_len;
        t_ccip_c0_req  req_type;
        logic [5:0]    rsvd0;
        t_ccip_clAddr  address;
        t_ccip_mdata   mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc      vc_used;
        logic          rsvd1;
        logic          hit_miss;
        logic [1:0]    rsvd0;
        logic [1:0]    cl_num;
        t_ccip_c0_rsp  resp_type;
        t_ccip_mdata   mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [15:0] rpc_id;
        logic [15:0] func_id;
        logic [31:0] arg0;
        logic [31:0] arg1;
        logic [31:0] arg2;
    } RpcIf;

    // Phase flag position inside each RX cache line; the host driver writes it.
    localparam int RX_FLAG_BIT = 511;
    // Flow id occupies mdata starting at this bit; all other mdata bits are zero.
    localparam int MDATA_FLOW_LSB = 0;

    typedef enum logic {RxIdle = 1'b0, RxIssue = 1'b1} RxState;

endpackage

// File: rtl/ccip_rx_flow_table.sv
// Per-flow RX ring state: next slot to poll, expected phase flag and
// whether a poll read is currently outstanding.
module ccip_rx_flow_table #(
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LRX_RING_SIZE     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] issue_flow,
    output logic                         issue_pending,
    output logic [LRX_RING_SIZE-1:0]     issue_slot,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] rsp_flow,
    output logic                         rsp_pending,
    output logic                         rsp_phase,
    input  logic                         set_pending,
    input  logic                         clr_pending,
    input  logic                         advance
);

    localparam int NUM_FLOWS = 1 << LMAX_NUM_OF_FLOWS;

    logic [LRX_RING_SIZE-1:0] slot [NUM_FLOWS];
    logic [NUM_FLOWS-1:0]     phase;
    logic [NUM_FLOWS-1:0]     pending;

    assign issue_pending = pending[issue_flow];
    assign issue_slot    = slot[issue_flow];
    assign rsp_pending   = pending[rsp_flow];
    assign rsp_phase     = phase[rsp_flow];

    // Set wins over clear so a fresh issue is never lost to a same-cycle response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) slot[i] <= '0;
            phase   <= '1;
            pending <= '0;
        end else begin
            if (clr_pending) pending[rsp_flow] <= 1'b0;
            if (set_pending) pending[issue_flow] <= 1'b1;
            if (advance) begin
                slot[rsp_flow] <= slot[rsp_flow] + 1'b1;
                if (slot[rsp_flow] == '1) phase[rsp_flow] <= ~phase[rsp_flow];
            end
        end
    end

endmodule

// File: rtl/ccip_receiver.sv
// RX path of the CPU-NIC interface: round-robin polls per-flow host rings
// with c0 reads and delivers lines whose phase flag marks them as new.
module ccip_receiver
    import nic_defs::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LRX_RING_SIZE     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  t_ccip_clAddr                 rx_base_addr,
    input  logic                         start,
    input  logic                         sRx_c0TxAlmFull,
    output t_if_ccip_c0_Tx               sTx_c0,
    input  t_if_ccip_c0_Rx               sRx_c0,
    output RpcIf                         rpc_out,
    output logic                         rpc_out_valid,
    output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
    output logic [31:0]                  rx_rpc_cnt,
    output logic                         error
);

    localparam int FLOW_W = LMAX_NUM_OF_FLOWS;

    RxState                   state;
    logic [FLOW_W-1:0]        rr_ptr;
    logic [FLOW_W-1:0]        rr_next;
    logic [FLOW_W-1:0]        rsp_flow;
    logic [LRX_RING_SIZE-1:0] issue_slot;
    logic                     issue_pending;
    logic                     rsp_pending;
    logic                     rsp_phase;
    logic                     rsp_hit;
    logic                     rsp_new;
    t_ccip_c0_ReqMemHdr       issue_hdr;
    logic                     unused_bits;

    assign unused_bits = ^{sRx_c0, NIC_ID};

    assign rsp_hit  = sRx_c0.rspValid && (sRx_c0.hdr.resp_type == eRSP_RDLINE);
    assign rsp_flow = sRx_c0.hdr.mdata[MDATA_FLOW_LSB +: FLOW_W];
    assign rsp_new  = rsp_hit && rsp_pending && (sRx_c0.data[RX_FLAG_BIT] == rsp_phase);
    assign rr_next  = (rr_ptr >= number_of_flows) ? '0 : rr_ptr + 1'b1;

    ccip_rx_flow_table #(
        .LMAX_NUM_OF_FLOWS(LMAX_NUM_OF_FLOWS),
        .LRX_RING_SIZE    (LRX_RING_SIZE)
    ) flow_table (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_flow   (rr_ptr),
        .issue_pending(issue_pending),
        .issue_slot   (issue_slot),
        .rsp_flow     (rsp_flow),
        .rsp_pending  (rsp_pending),
        .rsp_phase    (rsp_phase),
        .set_pending  (state == RxIssue),
        .clr_pending  (rsp_hit && rsp_pending),
        .advance      (rsp_new)
    );

    // {flow, slot} is exactly (flow << LRX_RING_SIZE) + slot.
    always_comb begin
        issue_hdr          = '0;
        issue_hdr.vc_sel   = eVC_VH0;
        issue_hdr.cl_len   = eCL_LEN_1;
        issue_hdr.req_type = eREQ_RDLINE_I;
        issue_hdr.address  = rx_base_addr + t_ccip_clAddr'({rr_ptr, issue_slot});
        issue_hdr.mdata[MDATA_FLOW_LSB +: FLOW_W] = rr_ptr;
    end

    // rr_ptr holds still on RxIdle->RxIssue, so in RxIssue it names the issued flow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RxIdle;
            rr_ptr <= '0;
            sTx_c0 <= '0;
        end else begin
            sTx_c0.valid <= 1'b0;
            case (state)
                RxIdle: begin
                    if (start && !sRx_c0TxAlmFull && !issue_pending) state <= RxIssue;
                    else rr_ptr <= rr_next;
                end
                RxIssue: begin
                    sTx_c0.valid <= 1'b1;
                    sTx_c0.hdr   <= issue_hdr;
                    rr_ptr       <= rr_next;
                    state        <= RxIdle;
                end
                default: state <= RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpc_out         <= '0;
            rpc_out_valid   <= 1'b0;
            rpc_flow_id_out <= '0;
            rx_rpc_cnt      <= '0;
            error           <= 1'b0;
        end else begin
            rpc_out_valid <= rsp_new;
            if (rsp_new) begin
                rpc_out         <= RpcIf'(sRx_c0.data[$bits(RpcIf)-1:0]);
                rpc_flow_id_out <= rsp_flow;
                rx_rpc_cnt      <= rx_rpc_cnt + 32'd1;
            end
            if (rsp_hit && !rsp_pending) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ccip_receiver.sv
// Directed bench for ccip_receiver: host-memory responder plus a ring-level
// model of which polls must deliver, checked every cycle.
`timescale 1ns/1ps
module tb_ccip_receiver;
    import nic_defs::*;

    localparam int LF = 1;
    localparam int LR = 2;
    localparam int NF = 2;
    localparam int NS = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [LF-1:0]       number_of_flows;
    t_ccip_clAddr        rx_base_addr;
    logic                start;
    logic                almfull;
    t_if_ccip_c0_Tx      sTx_c0;
    t_if_ccip_c0_Rx      sRx_c0;
    RpcIf                rpc_out;
    logic                rpc_out_valid;
    logic [LF-1:0]       rpc_flow_id_out;
    logic [31:0]         rx_rpc_cnt;
    logic                error;

    always #5 clk = ~clk;

    ccip_receiver #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .LRX_RING_SIZE(LR)) dut (
        .clk(clk), .reset_n(reset_n), .number_of_flows(number_of_flows),
        .rx_base_addr(rx_base_addr), .start(start), .sRx_c0TxAlmFull(almfull),
        .sTx_c0(sTx_c0), .sRx_c0(sRx_c0), .rpc_out(rpc_out), .rpc_out_valid(rpc_out_valid),
        .rpc_flow_id_out(rpc_flow_id_out), .rx_rpc_cnt(rx_rpc_cnt), .error(error)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host memory and ring-level model
    logic [511:0] mem [NF][NS];
    int           m_slot [NF];
    logic         m_phase [NF];
    logic         m_pend [NF];
    int           m_cnt;
    logic         m_err;
    logic         exp_v;
    RpcIf         exp_rpc;
    int           exp_flow;

    // Responder state
    logic         outst [NF];
    int           outst_slot [NF];
    int           outst_age [NF];
    logic         hold [NF];
    logic         inj_req;
    t_if_ccip_c0_Rx inj_rx;

    typedef struct {int flow; int offset; RpcIf rpc;} dlv_t;
    dlv_t         log_q[$];
    int           issue_cnt = 0;
    logic         prev_valid;
    t_ccip_clAddr last_addr;
    t_ccip_clAddr first_addr [NF];
    logic         seen [NF];
    int           af;
    int           rf;

    function automatic logic [511:0] mk_line(input logic flag, input logic [127:0] payload);
        logic [511:0] l;
        l = '0;
        l[127:0] = payload;
        l[200 +: 32] = 32'hDEAD_BEEF;
        l[RX_FLAG_BIT] = flag;
        return l;
    endfunction

    task automatic apply_rsp(input int f, input logic [511:0] data, input int slot_rd);
        if (!m_pend[f]) begin
            m_err = 1'b1;
        end else begin
            m_pend[f] = 1'b0;
            if (data[RX_FLAG_BIT] == m_phase[f]) begin
                exp_v    = 1'b1;
                exp_rpc  = RpcIf'(data[127:0]);
                exp_flow = f;
                m_cnt++;
                log_q.push_back('{f, f * NS + slot_rd, RpcIf'(data[127:0])});
                if (m_slot[f] == NS - 1) begin
                    m_slot[f]  = 0;
                    m_phase[f] = ~m_phase[f];
                end else begin
                    m_slot[f]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NF; i++) begin
                m_slot[i] = 0; m_phase[i] = 1'b1; m_pend[i] = 1'b0;
                outst[i] = 1'b0; outst_age[i] = 0; seen[i] = 1'b0;
            end
            m_cnt = 0; m_err = 1'b0; exp_v = 1'b0; prev_valid = 1'b0;
            sRx_c0 = '0;
        end else begin
            check("rpc_out_valid", 128'(rpc_out_valid), 128'(exp_v));
            if (exp_v) begin
                check("rpc_out", 128'(rpc_out), 128'(exp_rpc));
                check("rpc_flow_id_out", 128'(rpc_flow_id_out), 128'(exp_flow));
            end
            check("rx_rpc_cnt", 128'(rx_rpc_cnt), 128'(m_cnt));
            check("error", 128'(error), 128'(m_err));

            for (int i = 0; i < NF; i++) if (outst[i]) outst_age[i]++;
            if (sTx_c0.valid) begin
                af = int'(sTx_c0.hdr.mdata[LF-1:0]);
                check("issue_spacing", 128'(prev_valid), 128'(0));
                check("issue_addr", 128'(sTx_c0.hdr.address),
                      128'(t_ccip_clAddr'(rx_base_addr + t_ccip_clAddr'(af * NS + m_slot[af]))));
                check("issue_hdr", 128'({sTx_c0.hdr.req_type, sTx_c0.hdr.cl_len, sTx_c0.hdr.vc_sel,
                                         sTx_c0.hdr.mdata[15:LF]}),
                      128'({eREQ_RDLINE_I, eCL_LEN_1, eVC_VH0, 15'd0}));
                check("one_outstanding", 128'(m_pend[af]), 128'(0));
                m_pend[af] = 1'b1;
                outst[af] = 1'b1; outst_slot[af] = m_slot[af]; outst_age[af] = 0;
                issue_cnt++;
                last_addr = sTx_c0.hdr.address;
                if (!seen[af]) begin seen[af] = 1'b1; first_addr[af] = sTx_c0.hdr.address; end
            end
            prev_valid = sTx_c0.valid;

            sRx_c0 = '0;
            exp_v  = 1'b0;
            if (inj_req) begin
                inj_req = 1'b0;
                sRx_c0 = inj_rx;
                if (inj_rx.rspValid && inj_rx.hdr.resp_type == eRSP_RDLINE)
                    apply_rsp(int'(inj_rx.hdr.mdata[LF-1:0]), inj_rx.data, 0);
            end else begin
                rf = -1;
                for (int i = NF - 1; i >= 0; i--)
                    if (outst[i] && !hold[i] && outst_age[i] >= 1) rf = i;
                if (rf >= 0) begin
                    outst[rf] = 1'b0;
                    sRx_c0.rspValid = 1'b1;
                    sRx_c0.hdr.resp_type = eRSP_RDLINE;
                    sRx_c0.hdr.mdata = 16'(rf);
                    sRx_c0.data = mem[rf][outst_slot[rf]];
                    apply_rsp(rf, mem[rf][outst_slot[rf]], outst_slot[rf]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_dlv(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin step(1); k++; end
        check(name, 128'(log_q.size()), 128'(n));
    endtask

    task automatic inject(input logic rv, input logic mw, input t_ccip_c0_rsp rt, input int f);
        inj_rx = '0;
        inj_rx.rspValid = rv;
        inj_rx.mmioWrValid = mw;
        inj_rx.hdr.resp_type = rt;
        inj_rx.hdr.mdata = 16'(f);
        inj_rx.data = mk_line(1'b1, 128'h5A5A);
        inj_req = 1'b1;
    endtask

    logic [127:0] pay [6];
    int snap;
    int k;

    initial begin
        reset_n = 1'b0; start = 1'b0; almfull = 1'b0; number_of_flows = '0;
        rx_base_addr = 42'h1000; inj_req = 1'b0; inj_rx = '0; sRx_c0 = '0;
        for (int f = 0; f < NF; f++) begin
            hold[f] = 1'b0;
            for (int s = 0; s < NS; s++) mem[f][s] = '0;
        end
        for (int i = 0; i < 6; i++) pay[i] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0000 + 128'(i * 17 + 3);
        step(3);
        check("reset_tx_valid", 128'(sTx_c0.valid), 128'(0));
        check("reset_rpc_valid", 128'(rpc_out_valid), 128'(0));
        check("reset_flow_id", 128'(rpc_flow_id_out), 128'(0));
        check("reset_cnt", 128'(rx_rpc_cnt), 128'(0));
        check("reset_error", 128'(error), 128'(0));
        reset_n = 1'b1;

        // Stale slot 0: repeated polls of the same line, nothing delivered
        start = 1'b1;
        step(24);
        check("stale_cnt", 128'(rx_rpc_cnt), 128'(0));
        check("stale_polls", 128'(issue_cnt >= 3), 128'(1));
        check("stale_addr", 128'(last_addr), 128'(42'h1000));

        // First fresh RPC in slot 0, next poll moves to slot 1
        mem[0][0] = mk_line(1'b1, pay[0]);
        wait_dlv(1, 40, "first_delivery");
        snap = issue_cnt;
        k = 0;
        while (issue_cnt == snap && k < 20) begin step(1); k++; end
        check("next_poll_addr", 128'(last_addr), 128'(42'h1001));
        check("first_cnt", 128'(rx_rpc_cnt), 128'(1));
        check("first_payload", 128'(log_q[0].rpc), pay[0]);

        // Fill the rest of the ring and one wrapped slot with phase 0
        mem[0][1] = mk_line(1'b1, pay[1]);
        mem[0][2] = mk_line(1'b1, pay[2]);
        mem[0][3] = mk_line(1'b1, pay[3]);
        mem[0][0] = mk_line(1'b0, pay[4]);
        wait_dlv(5, 200, "ring_deliveries");
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            check("ring_offset", 128'(log_q[i].offset), 128'(i % 4));
            check("ring_payload", 128'(log_q[i].rpc), pay[i]);
        end
        step(30);
        check("ring_after_wrap", 128'(log_q.size()), 128'(5));
        check("ring_cnt", 128'(rx_rpc_cnt), 128'(5));

        // Two flows, flow 0 held so flow 1 completes first; base wraps
        start = 1'b0;
        step(10);
        reset_n = 1'b0;
        step(2);
        log_q.delete();
        rx_base_addr = 42'h3FF_FFFF_FFFE;
        number_of_flows = 1'b1;
        for (int f = 0; f < NF; f++) for (int s = 0; s < NS; s++) mem[f][s] = '0;
        mem[0][0] = mk_line(1'b1, pay[0]);
        mem[0][1] = mk_line(1'b1, pay[1]);
        mem[1][0] = mk_line(1'b1, pay[2]);
        mem[1][1] = mk_line(1'b1, pay[3]);
        hold[0] = 1'b1;
        reset_n = 1'b1;
        start = 1'b1;
        wait_dlv(2, 100, "flow1_first");
        check("oo_outstanding_f0", 128'(outst[0]), 128'(1));
        check("oo_first_addr_f0", 128'(first_addr[0]), 128'(42'h3FF_FFFF_FFFE));
        check("oo_first_addr_f1", 128'(first_addr[1]), 128'(42'h2));
        hold[0] = 1'b0;
        wait_dlv(4, 100, "flow0_after");
        if (log_q.size() >= 4) begin
            check("oo_flow_0", 128'(log_q[0].flow), 128'(1));
            check("oo_off_0", 128'(log_q[0].offset), 128'(4));
            check("oo_off_1", 128'(log_q[1].offset), 128'(5));
            check("oo_flow_2", 128'(log_q[2].flow), 128'(0));
            check("oo_pay_2", 128'(log_q[2].rpc), pay[0]);
            check("oo_pay_3", 128'(log_q[3].rpc), pay[1]);
        end

        // Almost-full backpressure
        number_of_flows = '0;
        step(10);
        almfull = 1'b1;
        step(2);
        snap = issue_cnt;
        step(18);
        check("almfull_blocks", 128'(issue_cnt - snap), 128'(0));
        almfull = 1'b0;
        k = 0;
        while (issue_cnt == snap && k < 2) begin step(1); k++; end
        check("almfull_resume", 128'(issue_cnt > snap), 128'(1));

        // Ignored traffic, then an unexpected response sets sticky error
        start = 1'b0;
        step(10);
        inject(1'b1, 1'b0, eRSP_UMSG, 1);
        step(2);
        check("umsg_ignored", 128'(error), 128'(0));
        inject(1'b0, 1'b1, eRSP_RDLINE, 1);
        step(2);
        check("mmio_ignored", 128'(error), 128'(0));
        inject(1'b1, 1'b0, eRSP_RDLINE, 1);
        step(2);
        check("spurious_error", 128'(error), 128'(1));
        step(5);
        check("error_sticky", 128'(error), 128'(1));

        // Reset with a read outstanding
        hold[0] = 1'b1;
        start = 1'b1;
        k = 0;
        while (!outst[0] && k < 20) begin step(1); k++; end
        check("read_outstanding", 128'(outst[0]), 128'(1));
        step(1);
        reset_n = 1'b0;
        #1;
        check("rst_tx_valid", 128'(sTx_c0.valid), 128'(0));
        check("rst_rpc_valid", 128'(rpc_out_valid), 128'(0));
        check("rst_flow_id", 128'(rpc_flow_id_out), 128'(0));
        check("rst_cnt", 128'(rx_rpc_cnt), 128'(0));
        check("rst_error", 128'(error), 128'(0));
        hold[0] = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
